// File: rtl/riscv_pkg.sv
// Shared RV32 constants for the execute-stage branch logic.
package riscv_pkg;

    localparam int XLEN_DEF = 32;
    localparam int PC_INCR  = 4;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/branch_cond_eval.sv
// Branch condition from the flags of op1-op2 (SUB); carry=1 means no borrow.
module branch_cond_eval
    import riscv_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       carry,
    input  logic       zero,
    input  logic       negative,
    input  logic       overflow,
    output logic       cond
);

    always_comb begin
        cond = 1'b0;
        case (funct3)
            F3_BEQ:  cond = zero;
            F3_BNE:  cond = !zero;
            F3_BLT:  cond = negative ^ overflow;
            F3_BGE:  cond = !(negative ^ overflow);
            F3_BLTU: cond = !carry;
            F3_BGEU: cond = carry;
            default: cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_branch_resolve_stage.sv
// EX-stage branch resolution: issues a one-cycle redirect, holds a flush window
// that swallows wrong-path beats, and registers survivors into the EX/MEM slot.
module ex_branch_resolve_stage
    import riscv_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int XLEN         = XLEN_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_imm,
    input  logic            in_is_branch,
    input  logic            in_is_jal,
    input  logic [2:0]      in_funct3,
    input  logic [4:0]      in_rd,
    input  logic            in_reg_write,
    input  logic [XLEN-1:0] alu_result,
    input  logic            carry_flag,
    input  logic            zero_flag,
    input  logic            negative_flag,
    input  logic            overflow_flag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [4:0]      out_rd,
    output logic            out_reg_write,
    output logic [XLEN-1:0] out_pc,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush
);

    localparam int CNT_W = (FLUSH_CYCLES < 1) ? 1 : $clog2(FLUSH_CYCLES + 1);

    logic            cond;
    logic            taken;
    logic            accept;
    logic            load;

    logic            valid_q, valid_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [4:0]      rd_q, rd_d;
    logic            reg_write_q, reg_write_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            redir_valid_q, redir_valid_d;
    logic [XLEN-1:0] redir_pc_q, redir_pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    branch_cond_eval u_cond (
        .funct3   (in_funct3),
        .carry    (carry_flag),
        .zero     (zero_flag),
        .negative (negative_flag),
        .overflow (overflow_flag),
        .cond     (cond)
    );

    assign taken    = in_is_jal | (in_is_branch & cond);
    assign in_ready = !valid_q | out_ready;
    assign accept   = in_valid & in_ready;
    // Beats accepted inside the flush window are wrong-path: consumed, never loaded.
    assign load     = accept & (cnt_q == '0);

    always_comb begin
        valid_d       = valid_q;
        result_d      = result_q;
        rd_d          = rd_q;
        reg_write_d   = reg_write_q;
        pc_d          = pc_q;
        redir_valid_d = 1'b0;
        redir_pc_d    = redir_pc_q;
        cnt_d         = cnt_q;

        if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end

        if (load) begin
            valid_d     = 1'b1;
            result_d    = in_is_jal ? (in_pc + XLEN'(PC_INCR)) : alu_result;
            rd_d        = in_rd;
            reg_write_d = in_reg_write & !in_is_branch;
            pc_d        = in_pc;
            if (taken) begin
                redir_valid_d = 1'b1;
                redir_pc_d    = in_pc + in_imm;
                cnt_d         = CNT_W'(FLUSH_CYCLES);
            end
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q       <= 1'b0;
            result_q      <= '0;
            rd_q          <= '0;
            reg_write_q   <= 1'b0;
            pc_q          <= '0;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= '0;
            cnt_q         <= '0;
        end else begin
            valid_q       <= valid_d;
            result_q      <= result_d;
            rd_q          <= rd_d;
            reg_write_q   <= reg_write_d;
            pc_q          <= pc_d;
            redir_valid_q <= redir_valid_d;
            redir_pc_q    <= redir_pc_d;
            cnt_q         <= cnt_d;
        end
    end

    assign out_valid      = valid_q;
    assign out_result     = result_q;
    assign out_rd         = rd_q;
    assign out_reg_write  = reg_write_q;
    assign out_pc         = pc_q;
    assign redirect_valid = redir_valid_q;
    assign redirect_pc    = redir_pc_q;
    assign flush          = (cnt_q != '0);

endmodule

// File: doc/ex_branch_resolve_stage.md
Name: ex_branch_resolve_stage

Overview:
Sits directly downstream of the execute-stage adder/ALU.
- Consumes the ALU result and its flags (carry, zero, negative, overflow) together with the instruction's control fields.
- Resolves conditional branches and JAL from those flags, issues a one-cycle PC redirect, and holds a flush window that discards wrong-path instructions.
- Registers surviving results into the EX/MEM pipeline slot under a valid/ready handshake.

Parameters:
FLUSH_CYCLES, 2, number of cycles flush stays asserted after a taken redirect (must be >= 1)
XLEN, 32, datapath width

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  upstream beat valid
in_ready  out  1  stage can accept beat
in_pc  in  XLEN  PC of the instruction
in_imm  in  XLEN  sign-extended branch/jump offset
in_is_branch  in  1  conditional branch
in_is_jal  in  1  unconditional jump
in_funct3  in  3  branch condition code
in_rd  in  5  destination register
in_reg_write  in  1  instruction writes rd
alu_result  in  XLEN  ALU output (op1-op2 for branches)
carry_flag  in  1  ALU carry-out (1 = no borrow on SUB)
zero_flag  in  1  ALU result zero
negative_flag  in  1  ALU result bit XLEN-1
overflow_flag  in  1  ALU signed overflow
out_valid  out  1  EX/MEM slot valid
out_ready  in  1  downstream accepts slot
out_result  out  XLEN  registered writeback value
out_rd  out  5  registered rd
out_reg_write  out  1  registered write enable
out_pc  out  XLEN  registered PC
redirect_valid  out  1  one-cycle redirect pulse
redirect_pc  out  XLEN  target PC
flush  out  1  front-end flush request

Behaviour:
- Reset (rst_n=0 at posedge): out_valid=0, out_result=0, out_rd=0, out_reg_write=0, out_pc=0, redirect_valid=0, redirect_pc=0, flush=0, flush counter=0.
- Reset mid-flush clears the counter immediately; no redirect is replayed.
- in_ready = (!out_valid | out_ready), combinational. A beat is accepted when in_valid & in_ready.
- Condition evaluation (combinational), from flags of SUB:
  - 000 BEQ: Z
  - 001 BNE: !Z
  - 100 BLT: N^V
  - 101 BGE: !(N^V)
  - 110 BLTU: !C
  - 111 BGEU: C
  - 010/011: never taken
- taken = in_is_jal | (in_is_branch & cond).
- Accept while flush counter == 0 (normal path):
  - Slot loads on the next edge with out_pc=in_pc.
  - out_result = in_pc+4 (mod 2^XLEN) for JAL, else alu_result.
  - out_rd=in_rd.
  - out_reg_write = in_reg_write & !in_is_branch.
  - If taken: next cycle redirect_valid=1 for exactly one cycle, redirect_pc = in_pc+in_imm (wraps mod 2^XLEN), counter loads FLUSH_CYCLES.
- flush = (counter != 0). The counter decrements by 1 each cycle while nonzero, so flush is high exactly FLUSH_CYCLES cycles, beginning in the same cycle as redirect_valid.
- Accept while counter != 0 (wrong path): the beat is consumed and discarded. No slot load, no redirect, counter unaffected, even if the beat is itself a taken branch.
- No accept and out_ready=1: out_valid clears.
- out_valid=1 and out_ready=0: all out_* hold stable, in_ready=0.
- Accept with out_ready=1 in the same cycle: the slot is overwritten (pass-through at full throughput).
- Latency: input to out_valid is 1 cycle; input to redirect_valid is 1 cycle.
- Branches occupy the slot (out_reg_write=0) so that retirement order is preserved.

Decomposition:
- Shared package/header riscv_pkg:
  - funct3 branch constants (F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU)
  - XLEN default
  - PC increment constant 4
- One natural sub-module: branch_cond_eval, a combinational unit taking funct3, carry, zero, negative and overflow, producing cond. It is reusable and unit-testable.

Test Plan:
- BEQ pc=0x100, imm=0x20, Z=1, out_ready=1 -> next cycle redirect_valid=1 with redirect_pc=0x120; flush high 2 cycles; out_reg_write=0.
- BLT with N=1,V=0 -> taken. BLT with N=1,V=1 -> not taken, no redirect, flush stays 0.
- BLTU C=1 -> not taken. BGEU C=1 -> taken. JAL pc=0xFFFFFFFC, imm=8 -> redirect_pc=0x4, out_result=0x0 (wrap).
- ADD result 0x55 rd=5 with out_ready=0 for 3 cycles -> in_ready=0 and out_* stable 3 cycles. After out_ready=1, in_ready=1 and the slot drains.
- Taken BEQ followed by two back-to-back taken BNE beats during flush -> both discarded, exactly one redirect pulse, no slot loads.
- rst_n=0 during the second flush cycle -> next cycle flush=0, redirect_valid=0, out_valid=0; the next normal ADD passes with 1-cycle latency.
